// File: rtl/mtimer.sv
// RISC-V machine timer: free-running 64-bit mtime, 64-bit mtimecmp and a registered
// timer-interrupt-pending line, exposed as a 16-byte slave with a request/ack handshake.
module mtimer #(
    parameter int PRESCALE = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_bus_en,
    input  logic        i_bus_we,
    input  logic [3:0]  i_bus_addr,
    input  logic [31:0] i_bus_wdata,
    output logic [31:0] o_bus_rdata,
    output logic        o_bus_ack,
    output logic        o_tip
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    typedef enum logic {ST_IDLE, ST_ACK} state_e;

    state_e        state_q, state_d;
    logic [63:0]   mtime_q, mtime_d;
    logic [63:0]   mtimecmp_q, mtimecmp_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          hi_valid_q, hi_valid_d;
    logic [31:0]   shadow_q, shadow_d;
    logic          tip_q, tip_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          tick;
    logic          access;
    logic          unused_addr;

    assign unused_addr = ^i_bus_addr[1:0];

    always_comb begin
        state_d    = state_q;
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        hi_valid_d = hi_valid_q;
        shadow_d   = shadow_q;
        rdata_d    = '0;
        tip_d      = (mtime_q >= mtimecmp_q);
        tick       = (pcnt_q == PMAX);
        access     = (state_q == ST_IDLE) && i_bus_en;
        pcnt_d     = tick ? '0 : pcnt_q + PW'(1);

        if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end

        case (state_q)
            ST_IDLE: if (i_bus_en) state_d = ST_ACK;
            default: state_d = ST_IDLE;
        endcase

        // An mtime write overrides the same-cycle increment and restarts the prescaler.
        if (access && i_bus_we) begin
            case (i_bus_addr[3:2])
                2'd0: begin
                    mtime_d    = {mtime_q[63:32], i_bus_wdata};
                    pcnt_d     = '0;
                    hi_valid_d = 1'b0;
                end
                2'd1: begin
                    mtime_d    = {i_bus_wdata, mtime_q[31:0]};
                    pcnt_d     = '0;
                    hi_valid_d = 1'b0;
                end
                2'd2:    mtimecmp_d = {mtimecmp_q[63:32], i_bus_wdata};
                default: mtimecmp_d = {i_bus_wdata, mtimecmp_q[31:0]};
            endcase
        end else if (access) begin
            case (i_bus_addr[3:2])
                2'd0: begin
                    rdata_d    = mtime_q[31:0];
                    shadow_d   = mtime_q[63:32];
                    hi_valid_d = 1'b1;
                end
                2'd1: begin
                    rdata_d    = hi_valid_q ? shadow_q : mtime_q[63:32];
                    hi_valid_d = 1'b0;
                end
                2'd2:    rdata_d = mtimecmp_q[31:0];
                default: rdata_d = mtimecmp_q[63:32];
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q    <= ST_IDLE;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            pcnt_q     <= '0;
            hi_valid_q <= 1'b0;
            shadow_q   <= '0;
            tip_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            pcnt_q     <= pcnt_d;
            hi_valid_q <= hi_valid_d;
            shadow_q   <= shadow_d;
            tip_q      <= tip_d;
            rdata_q    <= rdata_d;
        end
    end

    assign o_bus_ack   = (state_q == ST_ACK);
    assign o_bus_rdata = rdata_q;
    assign o_tip       = tip_q;

endmodule

// File: doc/mtimer.md
# mtimer

Memory-mapped RISC-V machine timer: a free-running 64-bit `mtime` counter and a 64-bit `mtimecmp` compare register. It drives the machine timer-interrupt-pending line that the CSR unit consumes as `i_Int_tip`, and so raises the `mip.MTIP` / `mcause` = 7 interrupt path. It sits on the core's data bus as a 16-byte slave with a single-request / single-ack handshake.

## Interface
- `PRESCALE`, default 1: `mtime` increments once every `PRESCALE` clocks; must be ≥ 1.
- `i_clk` input, 1: clock.
- `i_rst` input, 1: reset, synchronous, active-low.
- `i_bus_en` input, 1: request valid; held by the master until it sees `o_bus_ack`.
- `i_bus_we` input, 1: 1 = write, 0 = read.
- `i_bus_addr` input, 4: byte offset; only bits [3:2] are decoded, bits [1:0] are ignored.
  - 0x0: `mtime_lo`
  - 0x4: `mtime_hi`
  - 0x8: `mtimecmp_lo`
  - 0xC: `mtimecmp_hi`
- `i_bus_wdata` input, 32: write data; full-word writes only.
- `o_bus_rdata` output, 32: read data; valid only while `o_bus_ack` = 1, 0 otherwise.
- `o_bus_ack` output, 1: one-cycle completion pulse.
- `o_tip` output, 1: timer interrupt pending, registered.

## Operation
- **Reset values:**
  - `mtime` = 0
  - `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF
  - prescale count = 0
  - `hi_valid` = 0, shadow = 0
  - `o_tip` = 0, `o_bus_ack` = 0, `o_bus_rdata` = 0
  - FSM in IDLE
- **Bus FSM, two states:**
  - IDLE: if `i_bus_en` = 1, perform the access at this clock edge, register the read data, and go to ACK.
  - ACK: `o_bus_ack` = 1; `i_bus_en` is ignored; always return to IDLE.
  - The master drops `i_bus_en` in the cycle after ack. Back-to-back requests therefore complete every 2 cycles.
- **Prescaler:**
  - Counter runs 0..`PRESCALE`-1. When it reaches `PRESCALE`-1 it wraps to 0 and `mtime` increments.
  - `PRESCALE` = 1 means `mtime` increments every cycle.
- **`mtime` arithmetic:** 64-bit unsigned; FFFF_FFFF_FFFF_FFFF + 1 wraps to 0.
- **Writes:**
  - A write to `mtime_lo` or `mtime_hi` replaces that half only, and suppresses the increment in that cycle.
  - Any `mtime` write also clears the prescale count.
  - A write to `mtimecmp_lo` or `mtimecmp_hi` replaces that half only.
- **Reads:**
  - Reading `mtime_lo` returns the live low word, copies the live `mtime[63:32]` into the shadow, and sets `hi_valid`.
  - Reading `mtime_hi` returns the shadow if `hi_valid` = 1, else the live high word; either way it clears `hi_valid`.
  - Any `mtime` write clears `hi_valid`.
  - `mtimecmp` reads return the live value.
- **Interrupt:**
  - `o_tip` <= (`mtime` ≥ `mtimecmp`), 64-bit unsigned compare, evaluated every cycle on the current register values.
  - It stays level-high until `mtimecmp` is raised above `mtime` or `mtime` is written below `mtimecmp`.
  - There is no internal clear and no edge detection.
- **Half-word updates:** updating `mtimecmp` one half at a time can raise a transient `o_tip`. Software writes `mtimecmp_lo` = FFFF_FFFF first, then hi, then lo. The block takes no action to prevent this.

## Timing
- Request sampled at edge N; `o_bus_ack` and `o_bus_rdata` are high during cycle N+1. Ack latency is 1 cycle.
- Write data is visible in the registers after edge N.
- A read returns the register value before edge N: the same-edge increment is not included.
- `o_tip` lags any `mtime` or `mtimecmp` change by 1 cycle. Example: a compare write at edge N is reflected on `o_tip` after edge N+1.
- Simultaneous `mtime` write and prescaler tick: the write wins, there is no increment, and the prescale count returns to 0.
- Reset asserted in ACK state: the FSM returns to IDLE, ack drops at the next edge, and the pending read data is discarded.
- Reset asserted mid-prescale: the count is cleared.

## Test plan
- **Reset:** apply reset 3 cycles, release.
  - Read `mtimecmp_hi` -> FFFF_FFFF.
  - `o_tip` = 0.
  - The `mtime_lo` read returns 1 or more, counting up every cycle with `PRESCALE` = 1.
- **Prescale:** with `PRESCALE` = 4, write `mtime_lo` = 0, then wait 40 cycles.
  - `mtime_lo` read = 10 ± 1.
  - The count increments exactly every 4 cycles (checked by probe).
- **Carry and shadow:** write `mtime_hi` = 0, `mtime_lo` = FFFF_FFFE; let the low word wrap; read lo then hi.
  - Hi returns the value latched at the lo read: 0 if lo read ≥ FFFF_FFFE, else 1.
  - The hi read without a prior lo read returns the live high word.
- **Interrupt:** write `mtimecmp_hi` = 0, `mtimecmp_lo` = `mtime` + 20.
  - `o_tip` rises exactly 1 cycle after `mtime` reaches the compare value.
  - Writing `mtimecmp_lo` = FFFF_FFFF and `mtimecmp_hi` = FFFF_FFFF drops `o_tip` 1 cycle after the hi write.
- **Wrap:** write `mtime` = FFFF_FFFF_FFFF_FFFF with `mtimecmp` = 0.
  - `o_tip` = 1.
  - Next increment -> `mtime` = 0, `o_tip` stays 1 because 0 ≥ 0.
- **Handshake:** hold `i_bus_en` = 1 continuously on reads of 0x0.
  - `o_bus_ack` pulses every other cycle.
  - `o_bus_rdata` = 0 in every non-ack cycle.
